// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a one-cycle-latency FIFO into an AXI4-Stream master with packet framing.
module fifo_axis_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int PKT_LEN_BITS = 8,
  parameter int CNT_BITS     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [PKT_LEN_BITS-1:0] cfg_pkt_len,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    pkt_done,
  output logic [CNT_BITS-1:0]     pkt_count
);
  localparam logic [PKT_LEN_BITS-1:0] LEN_ONE = 1;
  localparam logic [CNT_BITS-1:0]     CNT_ONE = 1;
  logic [DATA_WIDTH-1:0]   buf_q [3];
  logic [1:0]              occ, head, tail;
  logic                    infl, pop;
  logic [PKT_LEN_BITS-1:0] bc, len_q, len_cur;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  // Reads are budgeted against buffered plus in-flight words so the buffer can never overflow.
  assign fifo_rd_en    = !i_rst && i_enable && !fifo_empty && (({1'b0, occ} + {2'b0, infl}) < 3'd3);
  assign m_axis_tvalid = occ != 2'd0;
  assign m_axis_tdata  = buf_q[head];
  assign pop           = m_axis_tvalid && m_axis_tready;
  // Length is live from cfg until the first beat of a packet, then held for the rest of it.
  assign len_cur       = bc == '0 ? cfg_pkt_len : len_q;
  assign m_axis_tlast  = m_axis_tvalid && (bc == len_cur - LEN_ONE);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      occ       <= '0;
      head      <= '0;
      tail      <= '0;
      infl      <= 1'b0;
      bc        <= '0;
      len_q     <= '0;
      pkt_done  <= 1'b0;
      pkt_count <= '0;
    end else begin
      infl     <= fifo_rd_en;
      pkt_done <= pop && m_axis_tlast;
      occ      <= occ + {1'b0, infl} - {1'b0, pop};
      if (infl) begin
        buf_q[tail] <= fifo_dout;
        tail        <= nxt(tail);
      end
      if (pop) begin
        head <= nxt(head);
        bc   <= m_axis_tlast ? '0 : bc + LEN_ONE;
        if (bc == '0) len_q <= cfg_pkt_len;
        if (m_axis_tlast) pkt_count <= pkt_count + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb_fifo_axis_reader: directed checks of FIFO draining, backpressure, framing, enable and reset.
module tb_fifo_axis_reader;
  logic        i_clk = 1'b0;
  logic        i_rst, i_enable, fifo_empty, fifo_rd_en;
  logic [7:0]  cfg_pkt_len;
  logic [31:0] fifo_dout = '0, m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, pkt_done;
  logic [15:0] pkt_count;

  fifo_axis_reader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .cfg_pkt_len(cfg_pkt_len),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .pkt_done(pkt_done), .pkt_count(pkt_count)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [1024];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge i_clk)
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end

  logic [31:0] bd [1024];
  logic        bl [1024];
  int          bcy [1024];
  int nb = 0, cyc = 0, ndone = 0, outst = 0;
  int empty_viol = 0, full_viol = 0, stab_viol = 0;
  logic stall = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  always @(posedge i_clk) begin
    cyc = cyc + 1;
    if (i_rst) begin
      outst = 0;
      stall = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty) empty_viol = empty_viol + 1;
      if (fifo_rd_en && outst >= 3) full_viol = full_viol + 1;
      if (stall && !(m_axis_tvalid && m_axis_tdata === pd && m_axis_tlast === pl)) stab_viol = stab_viol + 1;
      stall = m_axis_tvalid && !m_axis_tready;
      pd    = m_axis_tdata;
      pl    = m_axis_tlast;
      outst = outst + int'(fifo_rd_en) - int'(m_axis_tvalid && m_axis_tready);
      if (pkt_done) ndone = ndone + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        bd[nb]  = m_axis_tdata;
        bl[nb]  = m_axis_tlast;
        bcy[nb] = cyc;
        nb = nb + 1;
      end
    end
  end

  int checks = 0, errors = 0;
  int base, k, d0, t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int w = 0;
    while (nb < n && w < budget) begin
      @(negedge i_clk);
      w++;
    end
    chk(tag, 32'(nb >= n), 32'd1);
  endtask

  task automatic check_seq(input int b, input int n, input logic [31:0] first, input int len, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, " data"}, bd[b+i], first + 32'(i));
      chk({tag, " last"}, 32'(bl[b+i]), 32'((i % len) == len - 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; cfg_pkt_len = 8'd4; m_axis_tready = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    // Build nonzero state, then assert reset mid-cycle.
    cfg_pkt_len = 8'd1;
    push(32'hA0); push(32'hA1);
    i_enable = 1'b1; m_axis_tready = 1'b1;
    base = nb;
    wait_beats(base + 1, 10, "t1 beat");
    m_axis_tready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("t1 pre tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("t1 pre tdata", m_axis_tdata, 32'hA1);
    chk("t1 pre count", 32'(pkt_count), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rst tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst tdata", m_axis_tdata, 32'd0);
    chk("rst tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst done", 32'(pkt_done), 32'd0);
    chk("rst count", 32'(pkt_count), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_enable = 1'b0;
    @(negedge i_clk);
    chk("rst rd_en empty", 32'(fifo_rd_en), 32'd0);
    // Full throughput, L=4.
    cfg_pkt_len = 8'd4;
    for (int i = 0; i < 16; i++) push(32'(i));
    base = nb; d0 = ndone; m_axis_tready = 1'b1; t0 = cyc; i_enable = 1'b1;
    wait_beats(base + 16, 40, "t2 beats");
    repeat (2) @(negedge i_clk);
    chk("t2 latency", 32'(bcy[base]), 32'(t0 + 3));
    chk("t2 no bubble", 32'(bcy[base+15] - bcy[base]), 32'd15);
    check_seq(base, 16, 32'h0, 4, "t2");
    chk("t2 count", 32'(pkt_count), 32'd4);
    chk("t2 done pulses", 32'(ndone - d0), 32'd4);
    // Backpressure 1,0,0,1, L=8.
    cfg_pkt_len = 8'd8; base = nb;
    for (int i = 0; i < 8; i++) push(32'h20 + 32'(i));
    k = 0;
    while (nb < base + 8 && k < 100) begin
      m_axis_tready = (k % 4 == 0) || (k % 4 == 3);
      @(negedge i_clk);
      k++;
    end
    chk("t3 beats", 32'(nb - base), 32'd8);
    m_axis_tready = 1'b1;
    repeat (2) @(negedge i_clk);
    check_seq(base, 8, 32'h20, 8, "t3");
    chk("t3 count", 32'(pkt_count), 32'd5);
    // Sparse arrivals, L=3.
    cfg_pkt_len = 8'd3; base = nb;
    for (int i = 0; i < 3; i++) begin
      push(32'h30 + 32'(i));
      repeat (4) @(negedge i_clk);
    end
    wait_beats(base + 3, 10, "t4 beats");
    repeat (2) @(negedge i_clk);
    check_seq(base, 3, 32'h30, 3, "t4");
    chk("t4 gap1", 32'(bcy[base+1] - bcy[base]), 32'd4);
    chk("t4 gap2", 32'(bcy[base+2] - bcy[base+1]), 32'd4);
    chk("t4 count", 32'(pkt_count), 32'd6);
    // L=1.
    cfg_pkt_len = 8'd1; base = nb;
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(i));
    wait_beats(base + 3, 20, "t5 beats");
    repeat (2) @(negedge i_clk);
    check_seq(base, 3, 32'h40, 1, "t5");
    chk("t5 count", 32'(pkt_count), 32'd9);
    // cfg 0 means 256 beats.
    cfg_pkt_len = 8'd0; base = nb;
    for (int i = 0; i < 256; i++) push(32'h100 + 32'(i));
    wait_beats(base + 256, 300, "t6 beats");
    repeat (2) @(negedge i_clk);
    check_seq(base, 256, 32'h100, 256, "t6");
    chk("t6 count", 32'(pkt_count), 32'd10);
    // Length change mid-packet.
    cfg_pkt_len = 8'd4; base = nb;
    for (int i = 0; i < 6; i++) push(32'h200 + 32'(i));
    wait_beats(base + 1, 10, "t7 first");
    cfg_pkt_len = 8'd2;
    wait_beats(base + 6, 20, "t7 beats");
    repeat (2) @(negedge i_clk);
    for (int i = 0; i < 6; i++) begin
      chk("t7 data", bd[base+i], 32'h200 + 32'(i));
      chk("t7 last", 32'(bl[base+i]), 32'(i == 3 || i == 5));
    end
    chk("t7 count", 32'(pkt_count), 32'd12);
    // Enable drop with buffer plus in-flight full.
    m_axis_tready = 1'b0; cfg_pkt_len = 8'd3; base = nb;
    for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
    k = 0;
    while (outst < 3 && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    chk("t8 filled", 32'(outst), 32'd3);
    i_enable = 1'b0; m_axis_tready = 1'b1;
    repeat (10) @(negedge i_clk);
    chk("t8 drained", 32'(nb - base), 32'd3);
    chk("t8 tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t8 rd_en", 32'(fifo_rd_en), 32'd0);
    check_seq(base, 3, 32'h50, 3, "t8");
    chk("t8 count", 32'(pkt_count), 32'd13);
    cfg_pkt_len = 8'd2; i_enable = 1'b1;
    wait_beats(base + 5, 20, "t8 resume");
    repeat (2) @(negedge i_clk);
    check_seq(base + 3, 2, 32'h53, 2, "t8r");
    chk("t8r count", 32'(pkt_count), 32'd14);
    // Reset at bc=2.
    cfg_pkt_len = 8'd4; base = nb;
    for (int i = 0; i < 5; i++) push(32'h60 + 32'(i));
    wait_beats(base + 2, 20, "t9 beats");
    m_axis_tready = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("t9 held", 32'(nb - base), 32'd2);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("t9 count", 32'(pkt_count), 32'd0);
    chk("t9 tvalid", 32'(m_axis_tvalid), 32'd0);
    base = nb;
    for (int i = 0; i < 4; i++) push(32'h70 + 32'(i));
    m_axis_tready = 1'b1;
    wait_beats(base + 4, 20, "t9 new");
    repeat (2) @(negedge i_clk);
    check_seq(base, 4, 32'h70, 4, "t9n");
    chk("t9n count", 32'(pkt_count), 32'd1);
    chk("rd_en while empty", 32'(empty_viol), 32'd0);
    chk("rd_en while full", 32'(full_viol), 32'd0);
    chk("axis stability", 32'(stab_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
